// File: rtl/vga_sprite_engine.sv
// vga_sprite_engine: Wishbone-programmed sprite overlay with
// double-buffered position/attributes and a 2-stage pixel pipe.
module vga_sprite_engine #(
  parameter int NUM_SPRITES = 4,
  parameter int SPRITE_W    = 16,
  parameter int SPRITE_H    = 16,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [11:0] pixel_row,
  input  logic [11:0] pixel_column,
  input  logic        video_on,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        frame_sync,
  input  logic [11:0] bg_pixel,
  output logic [3:0]  VGA_R,
  output logic [3:0]  VGA_G,
  output logic [3:0]  VGA_B,
  output logic        VGA_HS,
  output logic        VGA_VS,
  input  logic [9:0]  i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic [3:0]  i_wb_sel,
  input  logic        i_wb_we,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack
);
  localparam int NS = NUM_SPRITES;
  localparam int BD = NS * SPRITE_H;
  localparam int BA = (BD > 1) ? $clog2(BD) : 1;
  localparam int XW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;

  logic [SPRITE_W-1:0] bmp_q [BD];

  logic          gen_en_q, gen_en_d;
  logic          pend_q, pend_d;
  logic [NS-1:0] coll_q, coll_d;
  logic [NS-1:0] w1c;
  logic [23:0]   spos_q [NS];
  logic [23:0]   spos_d [NS];
  logic [23:0]   apos_q [NS];
  logic [23:0]   apos_d [NS];
  logic [12:0]   sattr_q [NS];
  logic [12:0]   sattr_d [NS];
  logic [12:0]   aattr_q [NS];
  logic [12:0]   aattr_d [NS];
  logic          ack_q, ack_d;
  logic [31:0]   rdt_q, rdt_d;
  logic [NS-1:0] s1_hit_q, s1_hit_d;
  logic [14:0]   s1_q, s1_d;
  logic [11:0]   rgb_q, rgb_d;
  logic [1:0]    sync_q, sync_d;

  logic          req, wr, is_bmp;
  int            adr_i;
  logic [BA-1:0] wb_bi;
  logic [31:0]   mask, rd_word, old_w, new_w;

  always_comb begin
    mask = {{8{i_wb_sel[3]}}, {8{i_wb_sel[2]}},
            {8{i_wb_sel[1]}}, {8{i_wb_sel[0]}}};
    req = i_wb_cyc & i_wb_stb & ~ack_q;
    wr = i_wb_cyc & i_wb_stb & i_wb_we & ack_q;
    adr_i = int'(i_wb_adr);
    is_bmp = (adr_i >= 256) && (adr_i < 256 + BD);
    wb_bi = BA'(adr_i - 256);
    gen_en_d = gen_en_q;
    w1c = '0;
    pend_d = frame_sync ? 1'b0 : pend_q;
    rd_word = '0;
    old_w = '0;
    new_w = '0;
    if (adr_i == 0) begin
      rd_word = {pend_q, 15'b0, 8'(coll_q), 7'b0, gen_en_q};
      if (wr && i_wb_sel[0]) gen_en_d = i_wb_dat[0];
      if (wr && i_wb_sel[1]) w1c = NS'(i_wb_dat[15:8]);
    end
    if (is_bmp) rd_word = 32'(bmp_q[wb_bi]);
    for (int n = 0; n < NS; n++) begin
      spos_d[n] = spos_q[n];
      sattr_d[n] = sattr_q[n];
      apos_d[n] = frame_sync ? spos_q[n] : apos_q[n];
      aattr_d[n] = frame_sync ? sattr_q[n] : aattr_q[n];
      if (adr_i == 16 + 2 * n) begin
        old_w = {4'b0, spos_q[n][23:12], 4'b0, spos_q[n][11:0]};
        new_w = (old_w & ~mask) | (i_wb_dat & mask);
        rd_word = old_w;
        if (wr) begin
          spos_d[n] = {new_w[27:16], new_w[11:0]};
          pend_d = 1'b1;
        end
      end
      if (adr_i == 17 + 2 * n) begin
        old_w = {16'b0, sattr_q[n][12:1], 3'b0, sattr_q[n][0]};
        new_w = (old_w & ~mask) | (i_wb_dat & mask);
        rd_word = old_w;
        if (wr) begin
          sattr_d[n] = {new_w[15:4], new_w[0]};
          pend_d = 1'b1;
        end
      end
    end
    ack_d = req;
    rdt_d = req ? rd_word : '0;
  end

  logic [12:0]   col13, row13, x13, y13, dx, dy;
  logic [BA-1:0] bi;
  logic          clip, in_x, in_y, bit_v, multi;
  logic [11:0]   colour;

  always_comb begin
    col13 = {1'b0, pixel_column};
    row13 = {1'b0, pixel_row};
    clip = (int'(pixel_column) < H_ACTIVE) &&
           (int'(pixel_row) < V_ACTIVE);
    s1_hit_d = '0;
    x13 = '0; y13 = '0; dx = '0; dy = '0; bi = '0;
    in_x = 1'b0; in_y = 1'b0; bit_v = 1'b0;
    for (int n = 0; n < NS; n++) begin
      x13 = {1'b0, apos_q[n][11:0]};
      y13 = {1'b0, apos_q[n][23:12]};
      dx = col13 - x13;
      dy = row13 - y13;
      in_x = (col13 >= x13) && (col13 < x13 + 13'(SPRITE_W));
      in_y = (row13 >= y13) && (row13 < y13 + 13'(SPRITE_H));
      bi = BA'(n * SPRITE_H) + BA'(dy);
      bit_v = bmp_q[bi][dx[XW-1:0]];
      s1_hit_d[n] = gen_en_q & aattr_q[n][0] & video_on &
                    clip & in_x & in_y & bit_v;
    end
    s1_d = {bg_pixel, video_on, hsync_in, vsync_in};
    // Walk downward so the lowest-index hit wins.
    colour = s1_q[14:3];
    for (int n = NS - 1; n >= 0; n--)
      if (s1_hit_q[n]) colour = aattr_q[n][12:1];
    rgb_d = s1_q[2] ? colour : 12'h000;
    sync_d = s1_q[1:0];
    multi = |(s1_hit_q & (s1_hit_q - NS'(1)));
    coll_d = (coll_q & ~w1c) | (multi ? s1_hit_q : '0);
  end

  always_ff @(posedge clock) begin
    if (wr && is_bmp)
      bmp_q[wb_bi] <= (bmp_q[wb_bi] & ~mask[SPRITE_W-1:0]) |
                      (i_wb_dat[SPRITE_W-1:0] & mask[SPRITE_W-1:0]);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      gen_en_q <= 1'b0;
      pend_q <= 1'b0;
      coll_q <= '0;
      ack_q <= 1'b0;
      rdt_q <= '0;
      s1_hit_q <= '0;
      s1_q <= '0;
      rgb_q <= '0;
      sync_q <= '0;
      for (int n = 0; n < NS; n++) begin
        spos_q[n] <= '0;
        apos_q[n] <= '0;
        sattr_q[n] <= '0;
        aattr_q[n] <= '0;
      end
    end else begin
      gen_en_q <= gen_en_d;
      pend_q <= pend_d;
      coll_q <= coll_d;
      ack_q <= ack_d;
      rdt_q <= rdt_d;
      s1_hit_q <= s1_hit_d;
      s1_q <= s1_d;
      rgb_q <= rgb_d;
      sync_q <= sync_d;
      for (int n = 0; n < NS; n++) begin
        spos_q[n] <= spos_d[n];
        apos_q[n] <= apos_d[n];
        sattr_q[n] <= sattr_d[n];
        aattr_q[n] <= aattr_d[n];
      end
    end
  end

  assign VGA_R = rgb_q[11:8];
  assign VGA_G = rgb_q[7:4];
  assign VGA_B = rgb_q[3:0];
  assign VGA_HS = sync_q[1];
  assign VGA_VS = sync_q[0];
  assign o_wb_ack = ack_q;
  assign o_wb_rdt = rdt_q;
endmodule
